// File: rtl/bip_control_unit.sv
// bip_control_unit: multi-cycle control FSM for the accumulator datapath.
// Drives the program counter, holds the instruction register and decodes
// Moore-style selects and strobes for accumulator, ALU and data RAM.
// Handshake: there is no valid/ready pair. Enable=1 lets the FSM advance
// one step per clock. Enable=0 freezes every register and forces the three
// strobes low. Because the strobes come only from the current state and IR,
// a stalled EXEC/MEM step simply repeats when Enable returns. It never
// fires twice.
module bip_control_unit #(
  parameter int AB = 11,
  parameter int DB = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Enable,
  input  logic [DB-1:0] Instr,
  output logic [AB-1:0] PC,
  output logic [AB-1:0] Operand,
  output logic [1:0]    SelA,
  output logic          SelB,
  output logic          Op,
  output logic          WrAcc,
  output logic          WrRam,
  output logic          RdRam,
  output logic          Halted,
  output logic [DB-1:0] InstrCount
);

  localparam int OW = DB - AB;

  localparam logic [OW-1:0] OP_HLT  = OW'(0);
  localparam logic [OW-1:0] OP_STO  = OW'(1);
  localparam logic [OW-1:0] OP_LD   = OW'(2);
  localparam logic [OW-1:0] OP_LDI  = OW'(3);
  localparam logic [OW-1:0] OP_ADD  = OW'(4);
  localparam logic [OW-1:0] OP_ADDI = OW'(5);
  localparam logic [OW-1:0] OP_SUB  = OW'(6);
  localparam logic [OW-1:0] OP_SUBI = OW'(7);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AB-1:0] pc_q, pc_d;
  logic [DB-1:0] ir_q, ir_d;
  logic [DB-1:0] cnt_q, cnt_d;

  logic [OW-1:0] opcode;
  logic          wr_acc, wr_ram, rd_ram, halted;
  logic [1:0]    sel_a;
  logic          sel_b, alu_op;

  assign opcode = ir_q[DB-1:AB];

  // State, PC, IR and retired-instruction counter advance only while enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else if (Enable) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic plus Moore decode of selects and raw (ungated) strobes.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    wr_acc  = 1'b0;
    wr_ram  = 1'b0;
    rd_ram  = 1'b0;
    halted  = 1'b0;
    sel_a   = 2'b00;
    sel_b   = 1'b0;
    alu_op  = 1'b0;
    case (state_q)
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d    = Instr;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // Single-step instructions retire here; memory reads go on to MEM.
        state_d = S_FETCH;
        pc_d    = pc_q + AB'(1);
        cnt_d   = cnt_q + DB'(1);
        case (opcode)
          OP_HLT: begin
            state_d = S_HALT;
            pc_d    = pc_q;
            cnt_d   = cnt_q;
          end
          OP_STO: wr_ram = 1'b1;
          OP_LDI: begin
            wr_acc = 1'b1;
            sel_a  = 2'b01;
          end
          OP_ADDI, OP_SUBI: begin
            wr_acc = 1'b1;
            sel_a  = 2'b10;
            sel_b  = 1'b1;
            alu_op = (opcode == OP_SUBI);
          end
          OP_LD, OP_ADD, OP_SUB: begin
            rd_ram  = 1'b1;
            state_d = S_MEM;
            pc_d    = pc_q;
            cnt_d   = cnt_q;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        wr_acc  = 1'b1;
        if (opcode != OP_LD) begin
          sel_a  = 2'b10;
          sel_b  = 1'b0;
          alu_op = (opcode == OP_SUB);
        end
        pc_d    = pc_q + AB'(1);
        cnt_d   = cnt_q + DB'(1);
        state_d = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign PC         = pc_q;
  assign Operand    = ir_q[AB-1:0];
  assign InstrCount = cnt_q;
  assign SelA       = sel_a;
  assign SelB       = sel_b;
  assign Op         = alu_op;
  assign WrAcc      = wr_acc & Enable;
  assign WrRam      = wr_ram & Enable;
  assign RdRam      = rd_ram & Enable;
  assign Halted     = halted;

endmodule

// File: tb/tb_bip_control_unit.sv
// tb_bip_control_unit: directed program run through bip_control_unit with a
// per-cycle expected-output queue, plus a narrow-PC instance for wrap-around.
module tb_bip_control_unit;

  localparam int AB = 11;
  localparam int DB = 16;
  localparam int W  = 35;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, enable;
  logic [DB-1:0] instr;
  logic [AB-1:0] pc, operand;
  logic [1:0]    sel_a;
  logic          sel_b, op, wr_acc, wr_ram, rd_ram, halted;
  logic [DB-1:0] instr_count;

  bip_control_unit #(.AB(AB), .DB(DB)) dut (
    .clk(clk), .reset(reset), .Enable(enable), .Instr(instr),
    .PC(pc), .Operand(operand), .SelA(sel_a), .SelB(sel_b), .Op(op),
    .WrAcc(wr_acc), .WrRam(wr_ram), .RdRam(rd_ram), .Halted(halted),
    .InstrCount(instr_count)
  );

  // Narrow instance: AB=4, fed a constant NOP word (opcode 12'hF00).
  logic          reset_w;
  logic [3:0]    pc_w, operand_w;
  logic [1:0]    sel_a_w;
  logic          sel_b_w, op_w, wr_acc_w, wr_ram_w, rd_ram_w, halted_w;
  logic [DB-1:0] instr_count_w;

  bip_control_unit #(.AB(4), .DB(DB)) dut_w (
    .clk(clk), .reset(reset_w), .Enable(1'b1), .Instr(16'hF000),
    .PC(pc_w), .Operand(operand_w), .SelA(sel_a_w), .SelB(sel_b_w), .Op(op_w),
    .WrAcc(wr_acc_w), .WrRam(wr_ram_w), .RdRam(rd_ram_w), .Halted(halted_w),
    .InstrCount(instr_count_w)
  );

  // Program memory with one-cycle read latency.
  logic [DB-1:0] mem [0:15];
  always @(posedge clk) instr <= mem[pc[3:0]];

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [$];
  logic         care_q [$];
  int n_cmp  = 0;
  int n_fail = 0;
  logic [AB-1:0] e_pc;
  logic [DB-1:0] e_cnt;

  function automatic logic [W-1:0] pack(input logic wa, wr, rd, h,
                                        input logic [1:0] sa, input logic sb, o,
                                        input logic [AB-1:0] p, input logic [DB-1:0] c);
    return {wa, wr, rd, h, sa, sb, o, p, c};
  endfunction

  // Monitor: compare one expected entry per falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, obs, m;
      logic         care;
      e    = exp_q.pop_front();
      care = care_q.pop_front();
      obs  = pack(wr_acc, wr_ram, rd_ram, halted, sel_a, sel_b, op, pc, instr_count);
      m    = care ? '1 : ~(W'(4'hF) << 27);
      n_cmp++;
      assert ((obs & m) === (e & m)) else begin
        n_fail++;
        $error("FAIL cycle_outputs obs=%h exp=%h t=%0t", obs & m, e & m, $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input logic wa, wr, rd, h, input logic [1:0] sa,
                      input logic sb, o, input logic care);
    exp_q.push_back(pack(wa, wr, rd, h, sa, sb, o, e_pc, e_cnt));
    care_q.push_back(care);
    @(posedge clk); #1;
  endtask

  task automatic idle2();
    tick(0, 0, 0, 0, 2'b00, 0, 0, 0);
    tick(0, 0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  task automatic do_simple(input logic wa, wr, input logic [1:0] sa,
                           input logic sb, o, care);
    idle2();
    tick(wa, wr, 0, 0, sa, sb, o, care);
    e_pc++;
    e_cnt++;
  endtask

  task automatic do_mem(input logic [1:0] sa, input logic sb, o);
    idle2();
    tick(0, 0, 1, 0, 2'b00, 0, 0, 0);
    tick(1, 0, 0, 0, sa, sb, o, 1);
    e_pc++;
    e_cnt++;
  endtask

  task automatic check(input string tag, input logic [DB-1:0] obs, exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp_v);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h4000;   // NOP filler
    mem[0] = 16'h1FFF;  // LDI  0x7FF
    mem[1] = 16'h2010;  // ADD  0x010
    mem[2] = 16'h3805;  // SUBI 0x005
    mem[3] = 16'h0820;  // STO  0x020
    mem[4] = 16'h4000;  // NOP
    mem[5] = 16'h0000;  // HLT

    reset = 1'b1; reset_w = 1'b1; enable = 1'b1;
    e_pc = '0; e_cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pc", DB'(pc), 16'h0);
    check("reset_cnt", instr_count, 16'h0);
    check("reset_strobes", {13'h0, wr_acc, wr_ram, rd_ram}, 16'h0);
    check("reset_halted", {15'h0, halted}, 16'h0);
    reset = 1'b0;

    do_simple(1, 0, 2'b01, 0, 0, 1);          // LDI
    check("ldi_operand", DB'(operand), 16'h07FF);
    do_mem(2'b10, 0, 0);                      // ADD
    do_simple(1, 0, 2'b10, 1, 1, 1);          // SUBI
    // STO with a five-cycle stall in EXEC
    idle2();
    enable = 1'b0;
    repeat (5) tick(0, 0, 0, 0, 2'b00, 0, 0, 0);
    enable = 1'b1;
    tick(0, 1, 0, 0, 2'b00, 0, 0, 0);
    e_pc++;
    e_cnt++;
    do_simple(0, 0, 2'b00, 0, 0, 0);          // NOP
    // HLT, then sticky HALT for 20 cycles
    idle2();
    tick(0, 0, 0, 0, 2'b00, 0, 0, 0);
    repeat (20) tick(0, 0, 0, 1, 2'b00, 0, 0, 0);
    check("halt_pc", DB'(pc), 16'h0005);
    check("halt_cnt", instr_count, 16'h0005);

    reset = 1'b1;
    #1;
    check("halt_cleared", {15'h0, halted}, 16'h0);
    check("halt_reset_pc", DB'(pc), 16'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    e_pc = '0; e_cnt = '0;

    // Rerun LDI, then abort ADD in MEM with reset
    do_simple(1, 0, 2'b01, 0, 0, 1);
    idle2();
    tick(0, 0, 1, 0, 2'b00, 0, 0, 0);
    reset = 1'b1;
    #1;
    check("abort_wracc", {15'h0, wr_acc}, 16'h0);
    check("abort_pc", DB'(pc), 16'h0);
    check("abort_cnt", instr_count, 16'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // PC wrap on the AB=4 instance: 16 NOPs of 3 cycles each
    reset_w = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("wrap_pc_step", DB'(pc_w), 16'h1);
    repeat (45) @(posedge clk);
    #1;
    check("wrap_pc", DB'(pc_w), 16'h0);
    check("wrap_cnt", instr_count_w, 16'd16);

    check("queue_drained", DB'(exp_q.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
